// File: rtl/rv_fp_round_pipe_pkg.sv
// Shared definitions for the floating-point rounding pipeline.
//
// Holds the RISC-V rounding-mode encodings (INST_FRM_*) and two small helpers
// that resolve the dynamic mode and check mode validity. No ports.
package rv_fp_round_pipe_pkg;

    localparam logic [2:0] INST_FRM_RNE = 3'b000;
    localparam logic [2:0] INST_FRM_RTZ = 3'b001;
    localparam logic [2:0] INST_FRM_RDN = 3'b010;
    localparam logic [2:0] INST_FRM_RUP = 3'b011;
    localparam logic [2:0] INST_FRM_RMM = 3'b100;
    localparam logic [2:0] INST_FRM_DYN = 3'b111;

    // The instruction rm field selects the CSR frm when it holds the DYN code.
    function automatic logic [2:0] resolve_rm(input logic [2:0] rm, input logic [2:0] frm);
        return (rm == INST_FRM_DYN) ? frm : rm;
    endfunction

    // Only RNE..RMM are legal effective modes; 101/110/111 are reserved.
    function automatic logic rm_is_valid(input logic [2:0] rm);
        return (rm <= INST_FRM_RMM);
    endfunction

endpackage

// File: rtl/rv_fp_round_lane.sv
// One rounding lane: purely combinational.
//
// The lane has two independent halves that sit in different pipeline stages:
//   decision half (fed from the pipe inputs, result captured in S1)
//     dec_rm, dec_rm_ok     resolved mode and its validity
//     dec_sign, dec_rs      sign and {round, sticky} bits
//     dec_lsb               LSB of the unrounded magnitude (for RNE ties)
//     round_up              increment decision
//   add half (fed from S1 contents, result captured in S2)
//     add_active            lane enabled; inactive lanes output all zeros
//     add_abs, add_round_up magnitude and its increment decision
//     add_sign, add_rs, add_eff_sub, add_rm
//     abs_rounded, carry    rounded magnitude and wrap-past-all-ones flag
//     exact_zero, sign      exact-zero flag and final sign
module rv_fp_round_lane
    import rv_fp_round_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [2:0]            dec_rm,
    input  logic                  dec_rm_ok,
    input  logic                  dec_sign,
    input  logic [1:0]            dec_rs,
    input  logic                  dec_lsb,
    output logic                  round_up,

    input  logic                  add_active,
    input  logic [DATA_WIDTH-1:0] add_abs,
    input  logic                  add_round_up,
    input  logic                  add_sign,
    input  logic [1:0]            add_rs,
    input  logic                  add_eff_sub,
    input  logic [2:0]            add_rm,
    output logic [DATA_WIDTH-1:0] abs_rounded,
    output logic                  carry,
    output logic                  exact_zero,
    output logic                  sign
);

    logic [DATA_WIDTH:0] sum;
    logic                zero_raw;

    always_comb begin
        round_up = 1'b0;
        if (dec_rm_ok) begin
            case (dec_rm)
                // Ties go to even: round up on a tie only when the LSB is odd.
                INST_FRM_RNE: round_up = dec_rs[1] & (dec_rs[0] | dec_lsb);
                INST_FRM_RTZ: round_up = 1'b0;
                INST_FRM_RDN: round_up = (|dec_rs) & dec_sign;
                INST_FRM_RUP: round_up = (|dec_rs) & ~dec_sign;
                INST_FRM_RMM: round_up = dec_rs[1];
                default:      round_up = 1'b0;
            endcase
        end
    end

    always_comb begin
        sum      = {1'b0, add_abs} + {{DATA_WIDTH{1'b0}}, add_round_up};
        zero_raw = (add_abs == '0) && (add_rs == 2'b00);

        abs_rounded = '0;
        carry       = 1'b0;
        exact_zero  = 1'b0;
        sign        = 1'b0;
        if (add_active) begin
            abs_rounded = sum[DATA_WIDTH-1:0];
            carry       = sum[DATA_WIDTH];
            exact_zero  = zero_raw;
            // An exact zero from an effective subtraction is -0 only under RDN.
            sign        = (zero_raw && add_eff_sub) ? (add_rm == INST_FRM_RDN) : add_sign;
        end
    end

endmodule

// File: rtl/rv_fp_round_pipe.sv
// Multi-lane floating-point rounding pipeline, two register stages.
//
// S1 captures the request, the resolved rounding mode and per-lane round-up
// decisions; S2 captures the incremented magnitudes and flags. Valid/ready
// handshake on both sides; a full pipe can accept and drain in one cycle.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   valid_in/ready_in          input handshake
//   tag_in, lane_mask_in       opaque tag, active-lane mask
//   abs_value_in, sign_in, round_sticky_in, eff_sub_in   per-lane operands
//   rnd_mode_in, frm_in        instruction rm field, CSR dynamic mode
//   valid_out/ready_out        output handshake
//   tag_out, abs_rounded_out, sign_out, exact_zero_out, carry_out   results
//   rm_invalid_out, fflags_nx_out                                   flags
//
// Build option: RV_FP_ROUND_FLAGS_EN enables the rm_invalid/inexact flag
// logic; when undefined both flag ports are tied to zero.
module rv_fp_round_pipe
    import rv_fp_round_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned TAG_WIDTH  = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            valid_in,
    output logic                            ready_in,
    input  logic [TAG_WIDTH-1:0]            tag_in,
    input  logic [NUM_LANES-1:0]            lane_mask_in,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] abs_value_in,
    input  logic [NUM_LANES-1:0]            sign_in,
    input  logic [NUM_LANES*2-1:0]          round_sticky_in,
    input  logic [NUM_LANES-1:0]            eff_sub_in,
    input  logic [2:0]                      rnd_mode_in,
    input  logic [2:0]                      frm_in,
    output logic                            valid_out,
    input  logic                            ready_out,
    output logic [TAG_WIDTH-1:0]            tag_out,
    output logic [NUM_LANES*DATA_WIDTH-1:0] abs_rounded_out,
    output logic [NUM_LANES-1:0]            sign_out,
    output logic [NUM_LANES-1:0]            exact_zero_out,
    output logic [NUM_LANES-1:0]            carry_out,
    output logic                            rm_invalid_out,
    output logic                            fflags_nx_out
);

    logic en1, en2;
    logic [2:0] rm_res;
    logic rm_ok;
    logic [NUM_LANES-1:0] rup;

    // Stage 1 state
    logic                            valid_s1;
    logic [TAG_WIDTH-1:0]            tag_s1;
    logic [NUM_LANES-1:0]            mask_s1;
    logic [NUM_LANES*DATA_WIDTH-1:0] abs_s1;
    logic [NUM_LANES-1:0]            sign_s1;
    logic [NUM_LANES*2-1:0]          rs_s1;
    logic [NUM_LANES-1:0]            eff_sub_s1;
    logic [NUM_LANES-1:0]            rup_s1;
    logic [2:0]                      rm_s1;

    // Stage 2 state
    logic                            valid_s2;
    logic [TAG_WIDTH-1:0]            tag_s2;
    logic [NUM_LANES*DATA_WIDTH-1:0] abs_s2;
    logic [NUM_LANES-1:0]            sign_s2;
    logic [NUM_LANES-1:0]            zero_s2;
    logic [NUM_LANES-1:0]            carry_s2;

    // Lane add results feeding S2
    logic [NUM_LANES*DATA_WIDTH-1:0] abs_res;
    logic [NUM_LANES-1:0]            sign_res;
    logic [NUM_LANES-1:0]            zero_res;
    logic [NUM_LANES-1:0]            carry_res;

    assign en2      = ~valid_s2 | ready_out;
    assign en1      = ~valid_s1 | en2;
    assign ready_in = en1;

    assign rm_res = resolve_rm(rnd_mode_in, frm_in);
    assign rm_ok  = rm_is_valid(rm_res);

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        rv_fp_round_lane #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .dec_rm       (rm_res),
            .dec_rm_ok    (rm_ok),
            .dec_sign     (sign_in[l]),
            .dec_rs       (round_sticky_in[2*l +: 2]),
            .dec_lsb      (abs_value_in[l*DATA_WIDTH]),
            .round_up     (rup[l]),
            .add_active   (mask_s1[l]),
            .add_abs      (abs_s1[l*DATA_WIDTH +: DATA_WIDTH]),
            .add_round_up (rup_s1[l]),
            .add_sign     (sign_s1[l]),
            .add_rs       (rs_s1[2*l +: 2]),
            .add_eff_sub  (eff_sub_s1[l]),
            .add_rm       (rm_s1),
            .abs_rounded  (abs_res[l*DATA_WIDTH +: DATA_WIDTH]),
            .carry        (carry_res[l]),
            .exact_zero   (zero_res[l]),
            .sign         (sign_res[l])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_s1   <= 1'b0;
            tag_s1     <= '0;
            mask_s1    <= '0;
            abs_s1     <= '0;
            sign_s1    <= '0;
            rs_s1      <= '0;
            eff_sub_s1 <= '0;
            rup_s1     <= '0;
            rm_s1      <= '0;
        end else begin
            if (en1) begin
                valid_s1 <= valid_in;
            end
            // Data only moves on a real transfer so a stalled item is never disturbed.
            if (en1 && valid_in) begin
                tag_s1     <= tag_in;
                mask_s1    <= lane_mask_in;
                abs_s1     <= abs_value_in;
                sign_s1    <= sign_in;
                rs_s1      <= round_sticky_in;
                eff_sub_s1 <= eff_sub_in;
                rup_s1     <= rup;
                rm_s1      <= rm_res;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_s2 <= 1'b0;
            tag_s2   <= '0;
            abs_s2   <= '0;
            sign_s2  <= '0;
            zero_s2  <= '0;
            carry_s2 <= '0;
        end else begin
            if (en2) begin
                valid_s2 <= valid_s1;
            end
            if (en2 && valid_s1) begin
                tag_s2   <= tag_s1;
                abs_s2   <= abs_res;
                sign_s2  <= sign_res;
                zero_s2  <= zero_res;
                carry_s2 <= carry_res;
            end
        end
    end

    assign valid_out       = valid_s2;
    assign tag_out         = tag_s2;
    assign abs_rounded_out = abs_s2;
    assign sign_out        = sign_s2;
    assign exact_zero_out  = zero_s2;
    assign carry_out       = carry_s2;

`ifdef RV_FP_ROUND_FLAGS_EN
    logic                 rm_ok_s1;
    logic [NUM_LANES-1:0] rs_any;
    logic                 nx_res;
    logic                 nx_s2;
    logic                 rm_invalid_s2;

    always_comb begin
        rs_any = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            rs_any[l] = |rs_s1[2*l +: 2];
        end
    end

    // Reserved modes never report inexact since rounding was suppressed.
    assign nx_res = rm_ok_s1 & (|(rs_any & mask_s1));

    always_ff @(posedge clk) begin
        if (reset) begin
            rm_ok_s1      <= 1'b0;
            nx_s2         <= 1'b0;
            rm_invalid_s2 <= 1'b0;
        end else begin
            if (en1 && valid_in) begin
                rm_ok_s1 <= rm_ok;
            end
            if (en2 && valid_s1) begin
                nx_s2         <= nx_res;
                rm_invalid_s2 <= ~rm_ok_s1;
            end
        end
    end

    assign fflags_nx_out  = nx_s2;
    assign rm_invalid_out = rm_invalid_s2;
`else
    assign fflags_nx_out  = 1'b0;
    assign rm_invalid_out = 1'b0;
`endif

endmodule

// File: tb/tb_rv_fp_round_pipe.sv
// Self-checking bench for rv_fp_round_pipe: directed steps, scoreboard queue.
module tb_rv_fp_round_pipe;

    localparam int DW = 32;
    localparam int NL = 4;
    localparam int TW = 8;

`ifdef RV_FP_ROUND_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            valid_in;
    logic            ready_in;
    logic [TW-1:0]   tag_in;
    logic [NL-1:0]   lane_mask_in;
    logic [NL*DW-1:0] abs_value_in;
    logic [NL-1:0]   sign_in;
    logic [NL*2-1:0] round_sticky_in;
    logic [NL-1:0]   eff_sub_in;
    logic [2:0]      rnd_mode_in;
    logic [2:0]      frm_in;
    logic            valid_out;
    logic            ready_out;
    logic [TW-1:0]   tag_out;
    logic [NL*DW-1:0] abs_rounded_out;
    logic [NL-1:0]   sign_out;
    logic [NL-1:0]   exact_zero_out;
    logic [NL-1:0]   carry_out;
    logic            rm_invalid_out;
    logic            fflags_nx_out;

    always #5 clk = ~clk;

    rv_fp_round_pipe #(
        .DATA_WIDTH (DW),
        .NUM_LANES  (NL),
        .TAG_WIDTH  (TW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .valid_in        (valid_in),
        .ready_in        (ready_in),
        .tag_in          (tag_in),
        .lane_mask_in    (lane_mask_in),
        .abs_value_in    (abs_value_in),
        .sign_in         (sign_in),
        .round_sticky_in (round_sticky_in),
        .eff_sub_in      (eff_sub_in),
        .rnd_mode_in     (rnd_mode_in),
        .frm_in          (frm_in),
        .valid_out       (valid_out),
        .ready_out       (ready_out),
        .tag_out         (tag_out),
        .abs_rounded_out (abs_rounded_out),
        .sign_out        (sign_out),
        .exact_zero_out  (exact_zero_out),
        .carry_out       (carry_out),
        .rm_invalid_out  (rm_invalid_out),
        .fflags_nx_out   (fflags_nx_out)
    );

    typedef struct packed {
        logic [TW-1:0]    tag;
        logic [NL*DW-1:0] abs;
        logic [NL-1:0]    sign;
        logic [NL-1:0]    ez;
        logic [NL-1:0]    carry;
        logic             rminv;
        logic             nx;
        logic             chk_lat;
        logic [31:0]      cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   n_out  = 0;
    int   cyc    = 0;
    bit   lat_on = 1'b1;
    bit   accepted;
    int   n0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [NL*DW-1:0] got,
                       input logic [NL*DW-1:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model evaluated on the inputs at the moment of acceptance.
    function automatic exp_t model();
        exp_t     e;
        logic [2:0] m;
        bit       ok;
        e  = '0;
        m  = (rnd_mode_in == 3'b111) ? frm_in : rnd_mode_in;
        ok = (m < 3'd5);
        e.tag   = tag_in;
        e.rminv = FLAGS_EN && !ok;
        for (int l = 0; l < NL; l++) begin
            logic [DW-1:0] a;
            logic [1:0]    rs;
            logic          s;
            logic          up;
            a  = abs_value_in[l*DW +: DW];
            rs = round_sticky_in[l*2 +: 2];
            s  = sign_in[l];
            up = 1'b0;
            if (ok) begin
                case (m)
                    3'd0: up = (rs == 2'b11) || (rs == 2'b10 && a[0]);
                    3'd2: up = (rs != 2'b00) && s;
                    3'd3: up = (rs != 2'b00) && !s;
                    3'd4: up = rs[1];
                    default: up = 1'b0;
                endcase
            end
            if (lane_mask_in[l]) begin
                e.abs[l*DW +: DW] = a + {{(DW-1){1'b0}}, up};
                e.carry[l] = (a == {DW{1'b1}}) && up;
                e.ez[l]    = (a == '0) && (rs == 2'b00);
                e.sign[l]  = (e.ez[l] && eff_sub_in[l]) ? (m == 3'd2) : s;
                if (rs != 2'b00 && ok && FLAGS_EN) e.nx = 1'b1;
            end
        end
        e.chk_lat = lat_on;
        e.cyc     = cyc;
        return e;
    endfunction

    // One clock: sample/compare at negedge, then let the rising edge happen.
    task automatic step();
        exp_t e;
        @(negedge clk);
        accepted = 1'b0;
        if (!reset) begin
            if (valid_out && ready_out) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $error("FAIL spurious_out: observed valid_out=1 tag %0h expected none", tag_out);
                end else begin
                    e = sb.pop_front();
                    n_out++;
                    chk("tag", tag_out, e.tag);
                    chk("abs_rounded", abs_rounded_out, e.abs);
                    chk("sign", sign_out, e.sign);
                    chk("exact_zero", exact_zero_out, e.ez);
                    chk("carry", carry_out, e.carry);
                    chk("rm_invalid", rm_invalid_out, e.rminv);
                    chk("fflags_nx", fflags_nx_out, e.nx);
                    if (e.chk_lat) chk("latency", cyc - e.cyc, 2);
                end
            end
            if (valid_in && ready_in) begin
                sb.push_back(model());
                accepted = 1'b1;
            end
        end
        @(posedge clk);
        if (reset) sb.delete();
        #1;
    endtask

    // Lane 0 is directed; the other lanes get random operands.
    task automatic load(input logic [2:0] rm, input logic [2:0] frm, input logic [NL-1:0] mask,
                        input logic [TW-1:0] tag, input logic [DW-1:0] a0, input logic s0,
                        input logic [1:0] rs0, input logic es0);
        valid_in     = 1'b1;
        rnd_mode_in  = rm;
        frm_in       = frm;
        lane_mask_in = mask;
        tag_in       = tag;
        for (int l = 1; l < NL; l++) begin
            abs_value_in[l*DW +: DW]    = $urandom;
            sign_in[l]                  = 1'($urandom_range(0, 1));
            round_sticky_in[l*2 +: 2]   = 2'($urandom_range(0, 3));
            eff_sub_in[l]               = 1'($urandom_range(0, 1));
        end
        abs_value_in[0 +: DW]  = a0;
        sign_in[0]             = s0;
        round_sticky_in[0 +: 2] = rs0;
        eff_sub_in[0]          = es0;
    endtask

    task automatic drain(input int n);
        valid_in = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; ready_out = 1'b1; tag_in = '0; lane_mask_in = '0;
        abs_value_in = '0; sign_in = '0; round_sticky_in = '0; eff_sub_in = '0;
        rnd_mode_in = '0; frm_in = '0;
        repeat (3) step();
        reset = 1'b0;

        // Reset state
        chk("rst_valid_out", valid_out, 0);
        chk("rst_ready_in", ready_in, 1);
        chk("rst_tag", tag_out, 0);
        chk("rst_abs", abs_rounded_out, 0);
        chk("rst_flags", {sign_out, exact_zero_out, carry_out, rm_invalid_out, fflags_nx_out}, 0);

        // Streaming, RNE and a mix of modes, back to back
        load(3'b000, 3'b000, 4'hF, 8'h10, 32'h0000_0003, 1'b0, 2'b10, 1'b0); step();
        load(3'b000, 3'b000, 4'hF, 8'h11, 32'h0000_0002, 1'b0, 2'b10, 1'b0); step();
        load(3'b000, 3'b000, 4'hF, 8'h12, 32'h0000_0002, 1'b0, 2'b11, 1'b0); step();
        load(3'b001, 3'b000, 4'hF, 8'h13, 32'h0000_0007, 1'b0, 2'b11, 1'b0); step();
        load(3'b100, 3'b000, 4'hF, 8'h14, 32'h0000_0008, 1'b1, 2'b10, 1'b0); step();
        load(3'b011, 3'b000, 4'b0001, 8'h15, 32'h0000_0010, 1'b0, 2'b00, 1'b0); step();
        load(3'b010, 3'b000, 4'b0110, 8'h16, 32'h0000_0010, 1'b1, 2'b01, 1'b0); step();
        drain(3);

        // Dynamic mode through frm, then a reserved frm
        load(3'b111, 3'b010, 4'hF, 8'h20, 32'd5, 1'b1, 2'b01, 1'b0); step();
        load(3'b111, 3'b101, 4'hF, 8'h21, 32'd5, 1'b1, 2'b01, 1'b0); step();
        load(3'b110, 3'b000, 4'hF, 8'h22, 32'd9, 1'b0, 2'b11, 1'b0); step();
        load(3'b111, 3'b111, 4'hF, 8'h23, 32'd9, 1'b0, 2'b11, 1'b0); step();
        drain(3);

        // Increment wrapping past all-ones
        load(3'b011, 3'b000, 4'hF, 8'h30, 32'hFFFF_FFFF, 1'b0, 2'b01, 1'b0); step();
        load(3'b000, 3'b000, 4'hF, 8'h31, 32'hFFFF_FFFF, 1'b1, 2'b11, 1'b0); step();
        // Exact-zero sign under RDN and RNE
        load(3'b010, 3'b000, 4'hF, 8'h32, 32'd0, 1'b0, 2'b00, 1'b1); step();
        load(3'b000, 3'b000, 4'hF, 8'h33, 32'd0, 1'b1, 2'b00, 1'b1); step();
        load(3'b010, 3'b000, 4'hF, 8'h34, 32'd0, 1'b1, 2'b00, 1'b0); step();
        drain(3);

        // Backpressure: five stalled cycles, two accepts fill the pipe
        lat_on = 1'b0;
        ready_out = 1'b0;
        load(3'b000, 3'b000, 4'hF, 8'h01, 32'd11, 1'b0, 2'b10, 1'b0); step();
        chk("bp_accept1", accepted, 1);
        load(3'b000, 3'b000, 4'hF, 8'h02, 32'd12, 1'b0, 2'b10, 1'b0); step();
        chk("bp_accept2", accepted, 1);
        load(3'b001, 3'b000, 4'hF, 8'h03, 32'd13, 1'b0, 2'b11, 1'b0);
        chk("bp_ready_low", ready_in, 0);
        repeat (3) step();
        chk("bp_stall_accept", accepted, 0);
        chk("bp_hold_valid", valid_out, 1);
        chk("bp_hold_tag", tag_out, 8'h01);
        ready_out = 1'b1;
        n0 = n_out;
        step();
        chk("bp_accept3", accepted, 1);
        load(3'b011, 3'b000, 4'hF, 8'h04, 32'd14, 1'b0, 2'b01, 1'b0); step();
        chk("bp_accept4", accepted, 1);
        valid_in = 1'b0;
        step();
        step();
        chk("bp_no_gaps", n_out - n0, 4);
        drain(2);

        // Reset with two items in flight
        ready_out = 1'b0;
        load(3'b000, 3'b000, 4'hF, 8'h40, 32'd1, 1'b0, 2'b11, 1'b0); step();
        load(3'b000, 3'b000, 4'hF, 8'h41, 32'd2, 1'b0, 2'b11, 1'b0); step();
        valid_in = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        ready_out = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_flush_valid", valid_out, 0);
            step();
        end
        lat_on = 1'b1;
        n0 = n_out;
        load(3'b011, 3'b000, 4'hF, 8'h42, 32'd3, 1'b0, 2'b01, 1'b0); step();
        drain(3);
        chk("rst_next_out", n_out - n0, 1);
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_fp_round_pipe.md
RV_FP_ROUND_PIPE -- requirements
Module: RV_fp_round_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning width of one lane's unrounded magnitude.
REQ-002 SHALL have parameter NUM_LANES, default 4, meaning number of independent rounding lanes.
REQ-003 SHALL have parameter TAG_WIDTH, default 8, meaning width of the opaque request tag carried alongside data.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports valid_in  input  1  and ready_in  output  1, forming the input handshake.
REQ-007 SHALL have port tag_in  input  TAG_WIDTH  request tag, returned unchanged with the result.
REQ-008 SHALL have port lane_mask_in  input  NUM_LANES  active lanes; inactive lanes produce zero outputs and no flags.
REQ-009 SHALL have ports abs_value_in  input  NUM_LANES*DATA_WIDTH, sign_in  input  NUM_LANES, round_sticky_in  input  NUM_LANES*2, eff_sub_in  input  NUM_LANES; all per lane.
REQ-010 SHALL have ports rnd_mode_in  input  3  (instruction rm field, shared by all lanes) and frm_in  input  3  (CSR dynamic mode).
REQ-011 SHALL have ports valid_out  output  1  and ready_out  input  1, forming the output handshake.
REQ-012 SHALL have ports tag_out  TAG_WIDTH, abs_rounded_out  NUM_LANES*DATA_WIDTH, sign_out  NUM_LANES, exact_zero_out  NUM_LANES, carry_out  NUM_LANES (rounding increment wrapped past all-ones), all outputs.
REQ-013 SHALL have ports rm_invalid_out  output  1  and fflags_nx_out  output  1  (inexact, OR over active lanes).

Function
REQ-014 Effective mode SHALL be frm_in when rnd_mode_in is 111, otherwise rnd_mode_in; it is resolved in stage 1.
REQ-015 Round-up decision SHALL follow IEEE modes: RNE (rs 10 -> LSB, 11 -> 1, else 0), RTZ 0, RDN |rs & sign, RUP |rs & ~sign, RMM rs[1].
REQ-016 Effective mode 101, 110 or 111 SHALL force round-up 0 on all lanes and set rm_invalid_out for that result.
REQ-017 abs_rounded SHALL equal abs_value + round_up modulo 2^DATA_WIDTH; carry_out is set iff abs_value is all-ones and round_up is 1.
REQ-018 exact_zero SHALL be set iff abs_value == 0 and round_sticky == 00; sign_out is (effective mode == RDN) when exact_zero & eff_sub, else sign_in.
REQ-019 fflags_nx_out SHALL be set iff any active lane has round_sticky != 00 and the mode is valid.
REQ-020 The pipeline SHALL have two register stages: S1 latches inputs plus resolved mode and round-up bits; S2 latches add results and flags; latency 2 cycles with no stall.
REQ-021 Stage enables: en2 = ~valid_s2 | ready_out; en1 = ~valid_s1 | en2; ready_in = en1; a transfer occurs when valid and ready are both high.
REQ-022 Throughput SHALL be one result per cycle while ready_out stays high; stalls hold all stage contents unchanged, with no loss or duplication.
REQ-023 Results SHALL leave in acceptance order; valid_out equals valid_s2.
REQ-024 Simultaneous input accept and output drain on a full pipe SHALL advance both stages in the same cycle.

Reset
REQ-025 On reset, valid_s1, valid_s2 and valid_out SHALL be 0, and all data, tag and flag outputs SHALL be 0; ready_in is 1 in the first cycle after reset.
REQ-026 Reset asserted mid-operation SHALL discard in-flight items; no valid_out occurs for them.

Configuration
REQ-027 Macro RV_FP_ROUND_FLAGS_EN: when defined, fflags_nx_out and rm_invalid_out are computed per REQ-016/019; when undefined, both ports remain present but are tied to 0, and the flag logic is removed.

Structure
REQ-028 Rounding-mode encodings SHALL be taken from the INST_FRM_* constants in the shared define file; the module introduces no new mode constants.
REQ-029 The per-lane decision/add logic SHALL be one combinational sub-module, RV_fp_round_lane, instantiated NUM_LANES times via generate.

Verification
REQ-030 Streaming: with RNE, abs=0x00000003, rs=10, ready_out=1 -> abs_rounded=0x00000004 exactly 2 cycles after accept; abs=0x00000002, rs=10 -> 0x00000002.
REQ-031 Dynamic mode: rnd_mode=111, frm=010 (RDN), sign=1, abs=5, rs=01 -> 6, nx=1; then frm=101 -> rm_invalid=1, abs unchanged.
REQ-032 Wrap: RUP, sign=0, abs=0xFFFFFFFF, rs=01 -> abs_rounded=0, carry_out=1.
REQ-033 Zero sign: abs=0, rs=00, eff_sub=1 -> sign_out=1 under RDN and 0 under RNE; exact_zero=1.
REQ-034 Backpressure: hold ready_out=0 for 5 cycles while sending 4 tags 0x01..0x04 -> ready_in drops after 2 accepts; on release, tags appear in order 01,02,03,04 with no gaps.
REQ-035 Reset with 2 in flight -> valid_out stays 0 and the next accepted item emerges after 2 cycles.
